sseg_scan_ctrl: RTL

Scan scheduler for the 4-digit multiplexed seven-segment display path. It owns the digit scan sequence, driving the mux select and active-low anodes. It inserts a blanking dead-slot between digits to prevent ghosting and applies PWM brightness. It accepts atomic 4-digit value updates over a valid/ready handshake, committed only at frame boundaries. It sits upstream of the digit mux and hex-to-segment decoder, replacing the free-running ring counter.

---
 rtl/sseg_scan_ctrl_pkg.sv | 39 +++
 rtl/sseg_scan_ctrl_if.sv | 22 ++
 rtl/sseg_scan_ctrl_tick_gen.sv | 41 ++++
 rtl/sseg_scan_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_ctrl_pkg.sv
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared types and constants for the seven-segment scan
//                scheduler: scan FSM state encoding, digit/slot counts,
//                the all-anodes-off pattern and the leading-zero helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sseg_pkg;

    localparam int         N_DIGITS = 4;
    localparam int         N_SLOTS  = 16;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2,
        OFF  = 2'd3
    } scan_state_t;

    // A digit is a leading zero when it and every more-significant digit
    // are zero. Digit 0 always shows so a zero value still reads "0".
    function automatic logic lz_suppress(input logic [15:0] digits,
                                         input logic [1:0]  sel);
        logic sup;
        case (sel)
            2'd3:    sup = (digits[15:12] == 4'h0);
            2'd2:    sup = (digits[15:8]  == 8'h00);
            2'd1:    sup = (digits[15:4]  == 12'h000);
            default: sup = 1'b0;
        endcase
        return sup;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sseg_scan_ctrl_if.sv
// ============================================================================
//  Module      : sseg_scan_ctrl_if
//  Description : Display-value update handshake (valid/ready) carrying an
//                atomic 4-digit value, nibble i = digit i.
//                master : requester (drives upd_valid/upd_digits)
//                slave  : scan controller (drives upd_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sseg_scan_ctrl_if;

    logic        upd_valid;
    logic [15:0] upd_digits;
    logic        upd_ready;

    modport master (output upd_valid, output upd_digits, input  upd_ready);
    modport slave  (input  upd_valid, input  upd_digits, output upd_ready);

endinterface

`default_nettype wire

// File: rtl/sseg_scan_ctrl_tick_gen.sv
// ============================================================================
//  Module      : sseg_tick_gen
//  Description : Brightness-slot prescaler. Counts 0..TICK_DIV-1 and flags
//                the last count as a one-cycle slot tick.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                clr_i   - hold the count at zero (scan idle / disabled)
//                tick_o  - high while count = TICK_DIV-1 (and not cleared)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    output logic      tick_o
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick_o = !clr_i && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
// ============================================================================
//  Module      : sseg_scan_ctrl
//  Description : Scan scheduler for a 4-digit multiplexed seven-segment
//                display. Each digit period is 16 slots: slot 0 is a blank
//                dead slot, slots 1..bright_lat light the anode, the rest
//                stay dark. Value updates are held pending and committed
//                at frame boundaries (or immediately while idle).
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                enabled_i         - scan enable (0 = dark, scan idle)
//                brightness_i      - lit slots per digit period, 0..15
//                blank_lz_i        - suppress leading-zero digits
//                upd_if            - update handshake (slave side)
//                digits_active_o   - committed digit values
//                digit_sel_o       - current digit index
//                an_o              - active-low anodes (registered)
//                frame_done_o      - 1-cycle pulse after digit 3 ends
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        enabled_i,
    input  wire logic [3:0]  brightness_i,
    input  wire logic        blank_lz_i,
    sseg_scan_ctrl_if.slave  upd_if,
    output logic [15:0]      digits_active_o,
    output logic [1:0]       digit_sel_o,
    output logic [3:0]       an_o,
    output logic             frame_done_o
);

    scan_state_t state_q, state_d;
    logic [3:0]  slot_q, slot_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  bright_lat_q, bright_lat_d;
    logic [3:0]  an_q, an_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] digits_q, digits_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;

    logic        tick;
    logic        tick_clr;
    logic        frame_end;

    // Prescaler is parked at zero while idle so the first dead slot after
    // enabling is a full TICK_DIV cycles long.
    assign tick_clr = !enabled_i || (state_q == IDLE);

    sseg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    assign frame_end = enabled_i && tick && (slot_q == 4'(N_SLOTS - 1))
                     && (sel_q == 2'(N_DIGITS - 1))
                     && ((state_q == ON) || (state_q == OFF));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            sel_q        <= '0;
            bright_lat_q <= '0;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
            digits_q     <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            sel_q        <= sel_d;
            bright_lat_q <= bright_lat_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            digits_q     <= digits_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sel_d   = sel_q;
        if (!enabled_i) begin
            state_d = IDLE;
            slot_d  = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    slot_d  = '0;
                    sel_d   = '0;
                end
                DEAD: begin
                    if (tick) begin
                        slot_d  = slot_q + 4'd1;
                        state_d = (bright_lat_q != 4'd0) ? ON : OFF;
                    end
                end
                default: begin // ON, OFF
                    if (tick) begin
                        // Digit wrap wins over the ON->OFF check so that
                        // brightness 15 stays lit through slot 15.
                        if (slot_q == 4'(N_SLOTS - 1)) begin
                            slot_d  = '0;
                            sel_d   = sel_q + 2'd1;
                            state_d = DEAD;
                        end else begin
                            slot_d = slot_q + 4'd1;
                            if ((state_q == ON) && (slot_q == bright_lat_q)) begin
                                state_d = OFF;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Update handshake: capture when empty, commit at frame end or idle
    // ------------------------------------------------------------------
    always_comb begin
        digits_d   = digits_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (pend_vld_q && (frame_end || (state_q == IDLE))) begin
            digits_d   = pend_q;
            pend_vld_d = 1'b0;
        end
        // Commit needs pend_vld_q=1 and capture needs it 0, so the two
        // never collide.
        if (upd_if.upd_valid && !pend_vld_q) begin
            pend_d     = upd_if.upd_digits;
            pend_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered through the state register)
    // ------------------------------------------------------------------
    always_comb begin
        bright_lat_d = bright_lat_q;
        if ((state_d == DEAD) && (state_q != DEAD)) begin
            bright_lat_d = brightness_i;
        end
        frame_done_d = frame_end;
        an_d         = AN_OFF;
        if ((state_d == ON) && !(blank_lz_i && lz_suppress(digits_d, sel_d))) begin
            an_d = ~(4'b0001 << sel_d);
        end
    end

    assign upd_if.upd_ready = !pend_vld_q;
    assign digits_active_o  = digits_q;
    assign digit_sel_o      = sel_q;
    assign an_o             = an_q;
    assign frame_done_o     = frame_done_q;

endmodule

`default_nettype wire
